// File: rtl/mem_arbiter.sv
// Two-port round-robin read arbiter in front of a single-port memory.
// Sequences one registered read at a time and returns the word with a done pulse.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   p0_req/p0_addr       fetch port request (level) and byte address
//   p0_rdata/p0_done     fetch port read data (held) and one-cycle done pulse
//   p1_req/p1_addr       load port request (level) and byte address
//   p1_rdata/p1_done     load port read data (held) and one-cycle done pulse
//   mem_addr/mem_rstrb   registered address and read strobe to memory
//   mem_rdata            memory read data, valid the cycle after the strobe
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_done,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    logic   owner;
    logic   last_owner;
    logic   any_req;
    logic   pick1;

    // Port 1 wins when it is the only requester, or on a tie when
    // port 0 was served last (last_owner == 0).
    always_comb begin
        any_req = p0_req | p1_req;
        pick1   = p1_req & (~p0_req | ~last_owner);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            mem_addr   <= '0;
            mem_rstrb  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    p0_done <= 1'b0;
                    p1_done <= 1'b0;
                    if (any_req) begin
                        owner     <= pick1;
                        mem_addr  <= pick1 ? p1_addr : p0_addr;
                        mem_rstrb <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Strobe was presented this cycle; data arrives next.
                    mem_rstrb <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (owner) begin
                        p1_rdata <= mem_rdata;
                        p1_done  <= 1'b1;
                    end else begin
                        p0_rdata <= mem_rdata;
                        p0_done  <= 1'b1;
                    end
                    last_owner <= owner;
                    state      <= DONE;
                end
                DONE: begin
                    p0_done <= 1'b0;
                    p1_done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mem_rstrb <= 1'b0;
                    p0_done   <= 1'b0;
                    p1_done   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read memory.
// Each step samples 1 time unit after the rising edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p1_done;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int          passed = 0;
    int          total = 0;
    logic        prev_rstrb;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
    end

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .p0_req    (p0_req),
        .p0_addr   (p0_addr),
        .p0_rdata  (p0_rdata),
        .p0_done   (p0_done),
        .p1_req    (p1_req),
        .p1_addr   (p1_addr),
        .p1_rdata  (p1_rdata),
        .p1_done   (p1_done),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rstrb"}, mem_rstrb, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_p0done"}, p0_done, 0);
        chk({tag, "_p1done"}, p1_done, 0);
        chk({tag, "_p0rdata"}, p0_rdata, 0);
        chk({tag, "_p1rdata"}, p1_rdata, 0);
    endtask

    initial begin
        resetn  = 1'b0;
        p0_req  = 1'b0;
        p1_req  = 1'b0;
        p0_addr = '0;
        p1_addr = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[4]  = 32'hDEAD_BEEF;
        mem[12] = 32'h1234_5678;

        // reset state
        step;
        step;
        chk_reset("rst");
        resetn = 1'b1;
        step;
        chk("idle_rstrb", mem_rstrb, 0);

        // single read on port 0
        p0_req  = 1'b1;
        p0_addr = 32'h10;
        step;
        chk("single_t1_rstrb", mem_rstrb, 1);
        chk("single_t1_addr", mem_addr, 32'h10);
        chk("single_t1_done", p0_done, 0);
        step;
        chk("single_t2_rstrb", mem_rstrb, 0);
        chk("single_t2_done", p0_done, 0);
        step;
        chk("single_t3_done", p0_done, 1);
        chk("single_t3_rdata", p0_rdata, 32'hDEAD_BEEF);
        chk("single_t3_p1done", p1_done, 0);
        chk("single_t3_rstrb", mem_rstrb, 0);
        p0_req = 1'b0;
        step;
        chk("single_t4_done", p0_done, 0);
        chk("single_t4_rstrb", mem_rstrb, 0);

        // tie after reset: port 0 first
        resetn = 1'b0;
        step;
        resetn = 1'b1;
        chk("tie_rst_p0rdata", p0_rdata, 0);
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        p0_addr = 32'h0;
        p1_addr = 32'h20;
        step;
        chk("tie_t1_rstrb", mem_rstrb, 1);
        chk("tie_t1_addr", mem_addr, 32'h0);
        step;
        step;
        chk("tie_t3_p0done", p0_done, 1);
        chk("tie_t3_p0rdata", p0_rdata, 32'h1000_0000);
        chk("tie_t3_p1done", p1_done, 0);
        p0_req = 1'b0;
        step;
        chk("tie_t4_rstrb", mem_rstrb, 0);
        step;
        chk("tie_t5_rstrb", mem_rstrb, 1);
        chk("tie_t5_addr", mem_addr, 32'h20);
        step;
        step;
        chk("tie_t7_p1done", p1_done, 1);
        chk("tie_t7_p1rdata", p1_rdata, 32'h1000_0008);
        chk("tie_t7_p0done", p0_done, 0);
        p1_req = 1'b0;
        step;
        chk("tie_t8_p1done", p1_done, 0);

        // continuous contention: six reads alternating 0,1,...
        p0_req     = 1'b1;
        p1_req     = 1'b1;
        p0_addr    = 32'h14;
        p1_addr    = 32'h18;
        prev_rstrb = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step;
            chk("cont_p0done", p0_done, (k % 8 == 3) ? 1 : 0);
            chk("cont_p1done", p1_done, (k % 8 == 7) ? 1 : 0);
            chk("cont_rstrb", mem_rstrb, (k % 4 == 1) ? 1 : 0);
            chk("cont_no_b2b", prev_rstrb & mem_rstrb, 0);
            if (k % 8 == 3) chk("cont_p0rdata", p0_rdata, 32'h1000_0005);
            if (k % 8 == 7) chk("cont_p1rdata", p1_rdata, 32'h1000_0006);
            prev_rstrb = mem_rstrb;
            if (k == 23) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
        end

        // late request from port 1 during port 0 WAIT
        p0_req  = 1'b1;
        p0_addr = 32'h30;
        step;
        chk("late_t1_addr", mem_addr, 32'h30);
        step;
        p1_req  = 1'b1;
        p1_addr = 32'h24;
        step;
        chk("late_t3_p0done", p0_done, 1);
        chk("late_t3_p0rdata", p0_rdata, 32'h1234_5678);
        chk("late_t3_p1done", p1_done, 0);
        chk("late_t3_rstrb", mem_rstrb, 0);
        p0_req = 1'b0;
        step;
        chk("late_t4_rstrb", mem_rstrb, 0);
        step;
        chk("late_t5_rstrb", mem_rstrb, 1);
        chk("late_t5_addr", mem_addr, 32'h24);
        chk("hold_p0rdata", p0_rdata, 32'h1234_5678);
        step;
        chk("hold_p0rdata", p0_rdata, 32'h1234_5678);
        step;
        chk("late_t7_p1done", p1_done, 1);
        chk("late_t7_p1rdata", p1_rdata, 32'h1000_0009);
        p1_addr = 32'h28;

        // data hold: two more port 1 reads
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 4; c++) begin
                step;
                chk("hold_p0rdata", p0_rdata, 32'h1234_5678);
                chk("hold_p0done", p0_done, 0);
                if (c == 4) begin
                    chk("hold_p1done", p1_done, 1);
                    chk("hold_p1rdata", p1_rdata, 32'h1000_000A + r);
                end
            end
            p1_addr = 32'h2C;
        end
        p1_req = 1'b0;
        step;
        chk("hold_end_p1done", p1_done, 0);

        // port 0 read so that last_owner becomes 0
        p0_req  = 1'b1;
        p0_addr = 32'h10;
        step;
        step;
        step;
        chk("pre_rst_p0done", p0_done, 1);
        p0_req = 1'b0;
        step;

        // reset during port 0 WAIT
        p0_req = 1'b1;
        step;
        step;
        resetn = 1'b0;
        step;
        chk_reset("wrst");
        resetn  = 1'b1;
        p1_req  = 1'b1;
        p1_addr = 32'h20;
        step;
        chk("wrst_t1_rstrb", mem_rstrb, 1);
        chk("wrst_t1_addr", mem_addr, 32'h10);
        chk("wrst_t1_p0done", p0_done, 0);
        step;
        chk("wrst_t2_p0done", p0_done, 0);
        step;
        chk("wrst_t3_p0done", p0_done, 1);
        chk("wrst_t3_p0rdata", p0_rdata, 32'hDEAD_BEEF);
        chk("wrst_t3_p1done", p1_done, 0);
        p0_req = 1'b0;
        step;
        step;
        chk("wrst_t5_rstrb", mem_rstrb, 1);
        chk("wrst_t5_addr", mem_addr, 32'h20);
        step;
        step;
        chk("wrst_t7_p1done", p1_done, 1);
        chk("wrst_t7_p1rdata", p1_rdata, 32'h1000_0008);
        p1_req = 1'b0;
        step;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
